// File: rtl/reglist_encoder.sv
// reglist_encoder: walks a 16-bit register mask and emits each set
// bit's 4-bit address, one per valid/ready handshake, in priority order.
module reglist_encoder #(
    parameter bit ASCEND = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] reg_list,
    output logic [3:0]  addr_out,
    output logic        addr_valid,
    input  logic        addr_ready,
    output logic        busy,
    output logic        done,
    output logic [4:0]  count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t      state;
    logic [15:0] pending;
    logic [15:0] pend_next;

    // Priority pick: lowest set bit when ascending, highest otherwise.
    function automatic logic [3:0] pick(input logic [15:0] m);
        logic [3:0] r;
        r = 4'd0;
        if (ASCEND) begin
            for (int i = 15; i >= 0; i--)
                if (m[i]) r = 4'(i);
        end else begin
            for (int i = 0; i < 16; i++)
                if (m[i]) r = 4'(i);
        end
        return r;
    endfunction

    // Mask left over once the currently presented address is consumed.
    always_comb begin
        pend_next = pending & ~(16'd1 << addr_out);
    end

    // Control FSM; every output is registered, so addr_out/addr_valid
    // depend only on state and pending, never on live inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pending    <= 16'd0;
            addr_out   <= 4'd0;
            addr_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            count      <= 5'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        pending <= reg_list;
                        count   <= 5'd0;
                        busy    <= 1'b1;
                        if (reg_list != 16'd0) begin
                            state      <= SCAN;
                            addr_valid <= 1'b1;
                            addr_out   <= pick(reg_list);
                        end else begin
                            state <= FIN;
                            done  <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (addr_ready) begin
                        pending <= pend_next;
                        count   <= count + 5'd1;
                        if (pend_next == 16'd0) begin
                            state      <= FIN;
                            addr_valid <= 1'b0;
                            addr_out   <= 4'd0;
                            done       <= 1'b1;
                        end else begin
                            addr_out <= pick(pend_next);
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    addr_valid <= 1'b0;
                    addr_out   <= 4'd0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

endmodule
